alu_operand_fwd: RTL and testbench

Operand-select and EX pipeline-register stage that sits directly upstream of the ALU in the VLIW core. Each cycle it takes one decoded instruction from ID and resolves rs1/rs2 to final 32-bit operands, choosing among regfile read data, the ALU's combinational result (`alu_fwd`), the writeback value and immediate. It latches `op1`/`op2`/`aluctl` for the ALU and tracks the destination-register tags of the EX and WB stages. It detects load-use hazards, inserts bubbles and honours the global stall and flush.

---
 rtl/alu_operand_fwd.sv | 175 +++++++++++++++++
 tb/tb_alu_operand_fwd.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_fwd.sv
// Operand select and EX pipeline register ahead of the ALU: resolves rs1/rs2 with forwarding,
// inserts load-use bubbles and tracks EX/WB destination tags.
module alu_operand_fwd #(
   parameter int unsigned RA_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [5:0]      id_aluctl,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic [31:0]     id_rs1_val,
   input  logic [31:0]     id_rs2_val,
   input  logic [31:0]     id_imm,
   input  logic            id_use_imm,
   input  logic [RA_W-1:0] id_rd,
   input  logic            id_rd_we,
   input  logic            id_is_load,
   input  logic [31:0]     alu_fwd,
   input  logic [31:0]     wb_data,
   output logic [31:0]     ex_op1,
   output logic [31:0]     ex_op2,
   output logic [5:0]      ex_aluctl,
   output logic            ex_valid,
   output logic            ex_rd_we,
   output logic            ex_is_load,
   output logic [RA_W-1:0] ex_rd,
   output logic            wb_valid,
   output logic            wb_rd_we,
   output logic [RA_W-1:0] wb_rd,
   output logic            id_hold,
   output logic [15:0]     bubble_cnt
);

   logic [31:0]     ex_op1_q, ex_op1_d;
   logic [31:0]     ex_op2_q, ex_op2_d;
   logic [5:0]      ex_aluctl_q, ex_aluctl_d;
   logic            ex_valid_q, ex_valid_d;
   logic            ex_rd_we_q, ex_rd_we_d;
   logic            ex_is_load_q, ex_is_load_d;
   logic [RA_W-1:0] ex_rd_q, ex_rd_d;
   logic            wb_valid_q, wb_valid_d;
   logic            wb_rd_we_q, wb_rd_we_d;
   logic [RA_W-1:0] wb_rd_q, wb_rd_d;
   logic [15:0]     bubble_cnt_q, bubble_cnt_d;

   logic            ex_fwd_ok;
   logic            wb_fwd_ok;
   logic [31:0]     src1;
   logic [31:0]     src2;
   logic [31:0]     op2;
   logic            hazard;

   // Priority: x0, then the younger EX result, then WB, then the regfile read.
   function automatic logic [31:0] resolve(
      input logic [RA_W-1:0] rs,
      input logic [31:0]     rf_val,
      input logic            ex_ok,
      input logic [RA_W-1:0] ex_tag,
      input logic [31:0]     ex_val,
      input logic            wb_ok,
      input logic [RA_W-1:0] wb_tag,
      input logic [31:0]     wb_val
   );
      logic [31:0] res;
      if (rs == '0) begin
         res = '0;
      end else if (ex_ok && (ex_tag == rs)) begin
         res = ex_val;
      end else if (wb_ok && (wb_tag == rs)) begin
         res = wb_val;
      end else begin
         res = rf_val;
      end
      return res;
   endfunction

   always_comb begin
      ex_fwd_ok = ex_valid_q & ex_rd_we_q & ~ex_is_load_q;
      wb_fwd_ok = wb_valid_q & wb_rd_we_q;
      src1 = resolve(id_rs1, id_rs1_val, ex_fwd_ok, ex_rd_q, alu_fwd,
                     wb_fwd_ok, wb_rd_q, wb_data);
      src2 = resolve(id_rs2, id_rs2_val, ex_fwd_ok, ex_rd_q, alu_fwd,
                     wb_fwd_ok, wb_rd_q, wb_data);
      op2  = id_use_imm ? id_imm : src2;
      hazard = id_valid & ex_valid_q & ex_is_load_q & ex_rd_we_q & (ex_rd_q != '0) &
               ((ex_rd_q == id_rs1) | (~id_use_imm & (ex_rd_q == id_rs2)));
      id_hold = stall | (hazard & ~flush);
   end

   always_comb begin
      ex_op1_d     = ex_op1_q;
      ex_op2_d     = ex_op2_q;
      ex_aluctl_d  = ex_aluctl_q;
      ex_valid_d   = ex_valid_q;
      ex_rd_we_d   = ex_rd_we_q;
      ex_is_load_d = ex_is_load_q;
      ex_rd_d      = ex_rd_q;
      wb_valid_d   = wb_valid_q;
      wb_rd_we_d   = wb_rd_we_q;
      wb_rd_d      = wb_rd_q;
      bubble_cnt_d = bubble_cnt_q;

      if (!stall) begin
         wb_valid_d = ex_valid_q;
         wb_rd_we_d = ex_rd_we_q;
         wb_rd_d    = ex_rd_q;

         if (flush || hazard) begin
            ex_op1_d     = '0;
            ex_op2_d     = '0;
            ex_aluctl_d  = '0;
            ex_valid_d   = 1'b0;
            ex_rd_we_d   = 1'b0;
            ex_is_load_d = 1'b0;
            ex_rd_d      = '0;
            // A bubble coinciding with flush is charged to the flush, not to the hazard.
            if (!flush && (bubble_cnt_q != 16'hFFFF)) begin
               bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
         end else begin
            ex_op1_d     = src1;
            ex_op2_d     = op2;
            ex_aluctl_d  = id_aluctl;
            ex_valid_d   = id_valid;
            ex_rd_we_d   = id_rd_we;
            ex_is_load_d = id_is_load;
            ex_rd_d      = id_rd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_op1_q     <= '0;
         ex_op2_q     <= '0;
         ex_aluctl_q  <= '0;
         ex_valid_q   <= 1'b0;
         ex_rd_we_q   <= 1'b0;
         ex_is_load_q <= 1'b0;
         ex_rd_q      <= '0;
         wb_valid_q   <= 1'b0;
         wb_rd_we_q   <= 1'b0;
         wb_rd_q      <= '0;
         bubble_cnt_q <= '0;
      end else begin
         ex_op1_q     <= ex_op1_d;
         ex_op2_q     <= ex_op2_d;
         ex_aluctl_q  <= ex_aluctl_d;
         ex_valid_q   <= ex_valid_d;
         ex_rd_we_q   <= ex_rd_we_d;
         ex_is_load_q <= ex_is_load_d;
         ex_rd_q      <= ex_rd_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_we_q   <= wb_rd_we_d;
         wb_rd_q      <= wb_rd_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_op1     = ex_op1_q;
   assign ex_op2     = ex_op2_q;
   assign ex_aluctl  = ex_aluctl_q;
   assign ex_valid   = ex_valid_q;
   assign ex_rd_we   = ex_rd_we_q;
   assign ex_is_load = ex_is_load_q;
   assign ex_rd      = ex_rd_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd_we   = wb_rd_we_q;
   assign wb_rd      = wb_rd_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_alu_operand_fwd.sv
// Bench for alu_operand_fwd: an architectural register model predicts the correct operands of
// every issued instruction; a small ALU/regfile environment surrounds the DUT.
module tb_alu_operand_fwd;

   localparam int unsigned RA_W = 6;

   typedef struct packed {
      logic            v;
      logic [5:0]      ctl;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
      logic [31:0]     imm;
      logic            ui;
      logic            we;
      logic            ld;
   } instr_t;

   typedef struct packed {
      logic            v;
      logic            we;
      logic            ld;
      logic [RA_W-1:0] rd;
      logic [5:0]      ctl;
      logic [31:0]     a;
      logic [31:0]     b;
      logic [31:0]     res;
      logic            chk;
   } slot_t;

   logic            clk;
   logic            rst;
   logic            stall;
   logic            flush;
   logic            id_valid;
   logic [5:0]      id_aluctl;
   logic [RA_W-1:0] id_rs1;
   logic [RA_W-1:0] id_rs2;
   logic [31:0]     id_rs1_val;
   logic [31:0]     id_rs2_val;
   logic [31:0]     id_imm;
   logic            id_use_imm;
   logic [RA_W-1:0] id_rd;
   logic            id_rd_we;
   logic            id_is_load;
   logic [31:0]     alu_fwd;
   logic [31:0]     wb_data;
   logic [31:0]     ex_op1;
   logic [31:0]     ex_op2;
   logic [5:0]      ex_aluctl;
   logic            ex_valid;
   logic            ex_rd_we;
   logic            ex_is_load;
   logic [RA_W-1:0] ex_rd;
   logic            wb_valid;
   logic            wb_rd_we;
   logic [RA_W-1:0] wb_rd;
   logic            id_hold;
   logic [15:0]     bubble_cnt;

   alu_operand_fwd #(.RA_W(RA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .id_valid   (id_valid),
      .id_aluctl  (id_aluctl),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_rs1_val (id_rs1_val),
      .id_rs2_val (id_rs2_val),
      .id_imm     (id_imm),
      .id_use_imm (id_use_imm),
      .id_rd      (id_rd),
      .id_rd_we   (id_rd_we),
      .id_is_load (id_is_load),
      .alu_fwd    (alu_fwd),
      .wb_data    (wb_data),
      .ex_op1     (ex_op1),
      .ex_op2     (ex_op2),
      .ex_aluctl  (ex_aluctl),
      .ex_valid   (ex_valid),
      .ex_rd_we   (ex_rd_we),
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .wb_valid   (wb_valid),
      .wb_rd_we   (wb_rd_we),
      .wb_rd      (wb_rd),
      .id_hold    (id_hold),
      .bubble_cnt (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] rf   [64];
   logic [31:0] arch [64];
   slot_t       exm;
   slot_t       wbm;
   logic [15:0] bcnt;
   instr_t      cur;
   logic [31:0] junk_fwd;
   logic        did_rst;

   function automatic logic [31:0] alu_fn(input logic [5:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [31:0] r;
      case (ctl[1:0])
         2'd0:    r = a + b;
         2'd1:    r = a - b;
         2'd2:    r = a ^ b;
         default: r = (a << 1) + b;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_fn(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Multicycle ops: the ALU result is only final once the stall releases.
   assign alu_fwd = (ex_valid && !stall) ? alu_fn(ex_aluctl, ex_op1, ex_op2) : junk_fwd;

   function automatic slot_t bubble();
      slot_t s;
      s = '0;
      s.chk = 1'b1;
      return s;
   endfunction

   function automatic instr_t mk(input logic v, input logic [5:0] ctl, input int rs1,
                                 input int rs2, input int rd, input logic [31:0] imm,
                                 input logic ui, input logic we, input logic ld);
      instr_t i;
      i.v = v;
      i.ctl = ctl;
      i.rs1 = RA_W'(rs1);
      i.rs2 = RA_W'(rs2);
      i.rd = RA_W'(rd);
      i.imm = imm;
      i.ui = ui;
      i.we = we;
      i.ld = ld;
      return i;
   endfunction

   function automatic instr_t rnd_instr();
      return mk($urandom_range(0, 9) != 0, 6'($urandom_range(0, 63)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0);
   endfunction

   // The instruction in EX is a live load whose nonzero destination this ID instruction reads.
   function automatic logic hz_of(input instr_t i, input slot_t e);
      return i.v && e.v && e.ld && e.we && (e.rd != 0) &&
             ((e.rd == i.rs1) || (!i.ui && (e.rd == i.rs2)));
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("ex_valid", 32'(ex_valid), 32'(exm.v));
      check_eq("ex_rd_we", 32'(ex_rd_we), 32'(exm.we));
      check_eq("ex_is_load", 32'(ex_is_load), 32'(exm.ld));
      check_eq("ex_rd", 32'(ex_rd), 32'(exm.rd));
      check_eq("ex_aluctl", 32'(ex_aluctl), 32'(exm.ctl));
      if (exm.chk) begin
         check_eq("ex_op1", ex_op1, exm.a);
         check_eq("ex_op2", ex_op2, exm.b);
      end
      check_eq("wb_valid", 32'(wb_valid), 32'(wbm.v));
      check_eq("wb_rd_we", 32'(wb_rd_we), 32'(wbm.we));
      check_eq("wb_rd", 32'(wb_rd), 32'(wbm.rd));
      check_eq("bubble_cnt", 32'(bubble_cnt), 32'(bcnt));
   endtask

   task automatic cycle(input logic r, input logic st, input logic fl, output logic consumed);
      logic  hz;
      slot_t e;
      logic [31:0] a;
      logic [31:0] b;
      @(negedge clk);
      check_outputs();
      rst = r;
      stall = st;
      flush = fl;
      id_valid = cur.v;
      id_aluctl = cur.ctl;
      id_rs1 = cur.rs1;
      id_rs2 = cur.rs2;
      id_imm = cur.imm;
      id_use_imm = cur.ui;
      id_rd = cur.rd;
      id_rd_we = cur.we;
      id_is_load = cur.ld;
      // Garbage on x0 reads proves the zero rule does not rely on the regfile.
      id_rs1_val = (cur.rs1 == 0) ? $urandom : rf[cur.rs1];
      id_rs2_val = (cur.rs2 == 0) ? $urandom : rf[cur.rs2];
      wb_data = wbm.v ? wbm.res : $urandom;
      junk_fwd = $urandom;
      hz = hz_of(cur, exm);
      #1;
      check_eq("id_hold", 32'(id_hold), 32'(st | (hz & ~fl)));
      @(posedge clk);
      consumed = 1'b0;
      if (r) begin
         exm = bubble();
         wbm = bubble();
         bcnt = '0;
         for (int k = 0; k < 64; k++) arch[k] = rf[k];
      end else if (!st) begin
         if (wbm.v && wbm.we && wbm.rd != 0) rf[wbm.rd] = wbm.res;
         wbm = exm;
         if (fl) begin
            exm = bubble();
            consumed = 1'b1;
         end else if (hz) begin
            exm = bubble();
            if (bcnt != 16'hFFFF) bcnt = bcnt + 16'd1;
         end else begin
            a = arch[cur.rs1];
            b = cur.ui ? cur.imm : arch[cur.rs2];
            e.v = cur.v;
            e.we = cur.we;
            e.ld = cur.ld;
            e.rd = cur.rd;
            e.ctl = cur.ctl;
            e.a = a;
            e.b = b;
            e.res = cur.ld ? load_fn(a + b) : alu_fn(cur.ctl, a, b);
            e.chk = cur.v;
            if (cur.v && cur.we && cur.rd != 0) arch[cur.rd] = e.res;
            exm = e;
            consumed = 1'b1;
         end
      end
   endtask

   task automatic issue(input instr_t ins, input int nstall, input logic fl);
      logic c;
      c = 1'b0;
      cur = ins;
      for (int k = 0; k < nstall; k++) cycle(1'b0, 1'b1, fl, c);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 1'b0, fl, c);
         if (c) break;
      end
      check_eq("issue_consumed", 32'(c), 32'd1);
   endtask

   initial begin
      logic c;
      logic r;
      logic st;
      logic fl;
      for (int k = 0; k < 64; k++) begin
         rf[k] = '0;
         arch[k] = '0;
      end
      rf[5] = 32'd3;
      arch[5] = 32'd3;
      exm = bubble();
      wbm = bubble();
      bcnt = '0;
      did_rst = 1'b0;
      cur = '0;
      junk_fwd = '0;
      rst = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      id_valid = 1'b0;
      id_aluctl = '0;
      id_rs1 = '0;
      id_rs2 = '0;
      id_rs1_val = '0;
      id_rs2_val = '0;
      id_imm = '0;
      id_use_imm = 1'b0;
      id_rd = '0;
      id_rd_we = 1'b0;
      id_is_load = 1'b0;
      wb_data = '0;
      cycle(1'b1, 1'b0, 1'b0, c);
      cycle(1'b1, 1'b0, 1'b0, c);

      issue(mk(1, 6'd0, 5, 5, 6, 0, 0, 1, 0), 0, 0);      // x6 = 6
      issue(mk(1, 6'd0, 6, 6, 7, 0, 0, 1, 0), 0, 0);      // back-to-back via alu_fwd
      issue(mk(1, 6'd2, 1, 1, 13, 0, 0, 1, 0), 0, 0);     // unrelated
      issue(mk(1, 6'd0, 7, 0, 14, 0, 0, 1, 0), 0, 0);     // x7 from wb_data
      issue(mk(1, 6'd0, 0, 0, 8, 16, 1, 1, 1), 0, 0);     // load x8
      issue(mk(1, 6'd0, 8, 0, 9, 0, 0, 1, 0), 0, 0);      // load-use bubble
      issue(mk(1, 6'd0, 5, 0, 0, 4, 1, 1, 0), 0, 0);      // writes x0 = 7
      issue(mk(1, 6'd0, 0, 0, 15, 0, 0, 1, 0), 0, 0);
      issue(mk(1, 6'd0, 0, 0, 0, 8, 1, 1, 1), 0, 0);      // load to x0
      issue(mk(1, 6'd0, 0, 0, 16, 0, 0, 1, 0), 0, 0);     // no hazard on x0
      issue(mk(1, 6'd3, 5, 5, 20, 0, 0, 1, 0), 0, 0);     // multicycle producer
      issue(mk(1, 6'd0, 20, 0, 21, 0, 0, 1, 0), 3, 0);    // held by stall
      issue(mk(1, 6'd0, 5, 5, 22, 0, 0, 1, 0), 0, 1);     // flushed
      issue(mk(1, 6'd0, 0, 0, 23, 32, 1, 1, 1), 0, 0);    // load x23
      issue(mk(1, 6'd0, 23, 0, 24, 0, 0, 1, 0), 0, 1);    // flush + hazard
      issue(mk(1, 6'd0, 24, 23, 25, 0, 0, 1, 0), 0, 0);

      cur = rnd_instr();
      for (int i = 0; i < 1500; i++) begin
         r = (i > 400) && !did_rst && hz_of(cur, exm);
         if (r) did_rst = 1'b1;
         st = !r && ($urandom_range(0, 6) == 0);
         fl = $urandom_range(0, 11) == 0;
         cycle(r, st, fl, c);
         if (c || r) cur = rnd_instr();
      end
      @(negedge clk);
      check_outputs();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
